// File: rtl/uart_tft_pkg.sv
// Shared constants and types for the UART-to-TFT display path.
// Frame geometry, clocking figures and the byte-pairing state encoding.
package uart_tft_pkg;

   localparam int H_DISP       = 480;
   localparam int V_DISP       = 272;
   localparam int FRAME_PIXELS = H_DISP * V_DISP;
   localparam int FB_ADDR_W    = 17;
   localparam int CLK_HZ       = 50_000_000;
   localparam int BAUD         = 115200;
   localparam int BYTE_CYC     = 4340;

   typedef enum logic {
      WAIT_HI = 1'b0,
      WAIT_LO = 1'b1
   } pair_state_t;

endpackage

// File: rtl/uart_pixel_packer_if.sv
// Byte input and frame-RAM write bundle of the pixel packer.
// The packer uses slave; the byte source / RAM side uses master.
interface uart_pixel_packer_if #(
   parameter int ADDR_W = 17
);

   logic [7:0]        rx_data;
   logic              rx_done;
   logic              sync_clr;
   logic              ram_wren;
   logic [ADDR_W-1:0] ram_waddr;
   logic [15:0]       ram_wdata;
   logic              frame_done;
   logic              err_timeout;

   modport master (
      output rx_data,
      output rx_done,
      output sync_clr,
      input  ram_wren,
      input  ram_waddr,
      input  ram_wdata,
      input  frame_done,
      input  err_timeout
   );

   modport slave (
      input  rx_data,
      input  rx_done,
      input  sync_clr,
      output ram_wren,
      output ram_waddr,
      output ram_wdata,
      output frame_done,
      output err_timeout
   );

endinterface

// File: rtl/pixel_addr_gen.sv
// Frame-RAM write address counter wrapping at PIXELS-1.
// frame_done is registered so it lines up with the write pulse.
module pixel_addr_gen
   import uart_tft_pkg::*;
#(
   parameter int PIXELS = FRAME_PIXELS,
   parameter int ADDR_W = FB_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              adv,
   output logic [ADDR_W-1:0] addr,
   output logic              frame_done
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PIXELS - 1);

   logic [ADDR_W-1:0] addr_q;
   logic              at_last;

   assign at_last = (addr_q == LAST);
   assign addr    = addr_q;

   // advance or restart the address; wrap back to 0 after the last pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
      end else if (clr) begin
         addr_q <= '0;
      end else if (adv) begin
         addr_q <= at_last ? '0 : addr_q + 1'b1;
      end
   end

   // flag the write that lands on the last pixel of the frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done <= 1'b0;
      end else begin
         frame_done <= adv && !clr && at_last;
      end
   end

endmodule

// File: rtl/uart_pixel_packer.sv
// Packs UART bytes (high first) into RGB565 words for the frame RAM.
// A stalled pair is dropped after TIMEOUT_CYC so pairing resynchronises.
module uart_pixel_packer
   import uart_tft_pkg::*;
#(
   parameter int PIXELS      = FRAME_PIXELS,
   parameter int ADDR_W      = FB_ADDR_W,
   parameter int TIMEOUT_CYC = 21700
) (
   input  logic           Clk,
   input  logic           Reset_n,
   uart_pixel_packer_if.slave bus
);

   localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

   pair_state_t       state_q;
   pair_state_t       state_d;
   logic [7:0]        hi_q;
   logic [7:0]        hi_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              wr_req;
   logic              to_evt;

   logic [ADDR_W-1:0] addr;
   logic              frame_done;

   logic              wren_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [15:0]       wdata_q;
   logic              err_q;

   pixel_addr_gen #(
      .PIXELS (PIXELS),
      .ADDR_W (ADDR_W)
   ) u_addr (
      .clk        (Clk),
      .rst_n      (Reset_n),
      .clr        (bus.sync_clr),
      .adv        (wr_req),
      .addr       (addr),
      .frame_done (frame_done)
   );

   // pairing state, pending high byte and inter-byte counter
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= WAIT_HI;
         hi_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
      end
   end

   // next pairing state; sync_clr beats a byte, a byte beats the timeout
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      cnt_d   = cnt_q;
      wr_req  = 1'b0;
      to_evt  = 1'b0;
      if (bus.sync_clr) begin
         state_d = WAIT_HI;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            WAIT_HI: begin
               if (bus.rx_done) begin
                  hi_d    = bus.rx_data;
                  cnt_d   = '0;
                  state_d = WAIT_LO;
               end
            end
            WAIT_LO: begin
               if (bus.rx_done) begin
                  wr_req  = 1'b1;
                  cnt_d   = '0;
                  state_d = WAIT_HI;
               end else if (cnt_q == CNT_MAX) begin
                  to_evt  = 1'b1;
                  hi_d    = '0;
                  cnt_d   = '0;
                  state_d = WAIT_HI;
               end else begin
                  cnt_d   = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = WAIT_HI;
            end
         endcase
      end
   end

   // registered write port; address and data hold between writes
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wren_q  <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         wren_q <= wr_req;
         err_q  <= to_evt;
         if (wr_req) begin
            waddr_q <= addr;
            wdata_q <= {hi_q, bus.rx_data};
         end
      end
   end

   assign bus.ram_wren    = wren_q;
   assign bus.ram_waddr   = waddr_q;
   assign bus.ram_wdata   = wdata_q;
   assign bus.frame_done  = frame_done;
   assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Directed bench for uart_pixel_packer with a short frame and timeout.
// Byte strobes are driven on negedges; outputs are read on negedges.
module tb_uart_pixel_packer;

   localparam int PIX = 24;
   localparam int AW  = 5;
   localparam int TO  = 2170;
   localparam int GAP = 434;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   n_wr;
   int   n_fd;
   int   n_err;

   uart_pixel_packer_if #(.ADDR_W(AW)) bus ();

   uart_pixel_packer #(
      .PIXELS      (PIX),
      .ADDR_W      (AW),
      .TIMEOUT_CYC (TO)
   ) dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.ram_wren)    n_wr  = n_wr + 1;
         if (bus.frame_done)  n_fd  = n_fd + 1;
         if (bus.err_timeout) n_err = n_err + 1;
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // caller sits just after a negedge; strobe is one cycle wide
   task automatic send_byte(input logic [7:0] b,
                            output logic wr,
                            output logic [AW-1:0] a,
                            output logic [15:0] d,
                            output logic fd);
      bus.rx_data = b;
      bus.rx_done = 1'b1;
      @(negedge clk);
      bus.rx_done = 1'b0;
      wr = bus.ram_wren;
      a  = bus.ram_waddr;
      d  = bus.ram_wdata;
      fd = bus.frame_done;
   endtask

   task automatic send_pixel(input logic [15:0] px,
                             input logic [AW-1:0] ea,
                             input logic efd,
                             input string nm);
      logic wr;
      logic [AW-1:0] a;
      logic [15:0] d;
      logic fd;
      send_byte(px[15:8], wr, a, d, fd);
      idle(GAP);
      send_byte(px[7:0], wr, a, d, fd);
      total++;
      if ({wr, a, d, fd} !== {1'b1, ea, px, efd}) begin
         bad++;
         $display("FAIL %s: got wr=%b a=%0d d=%h fd=%b want wr=1 a=%0d d=%h fd=%b",
                  nm, wr, a, d, fd, ea, px, efd);
      end
      @(negedge clk);
      total++;
      if (bus.ram_wren !== 1'b0) begin
         bad++;
         $display("FAIL %s_pulse: wren=%b want 0", nm, bus.ram_wren);
      end
      idle(GAP);
   endtask

   task automatic check_outs_zero(input string nm);
      total++;
      if ({bus.ram_wren, bus.ram_waddr, bus.ram_wdata,
           bus.frame_done, bus.err_timeout} !== '0) begin
         bad++;
         $display("FAIL %s: wren=%b a=%0d d=%h fd=%b err=%b want all 0",
                  nm, bus.ram_wren, bus.ram_waddr, bus.ram_wdata,
                  bus.frame_done, bus.err_timeout);
      end
   endtask

   task automatic check_cnt(input string nm, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, got, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.rx_data = 8'h00;
      bus.rx_done = 1'b0;
      bus.sync_clr = 1'b0;
      idle(4);
      check_outs_zero("reset_state");
      rst_n = 1'b1;
      idle(3);
      check_outs_zero("after_reset");
   endtask

   task automatic test_pixels();
      int w0, f0, e0;
      w0 = n_wr; f0 = n_fd; e0 = n_err;
      for (int i = 0; i < 16; i++)
         send_pixel(16'(i), AW'(i), 1'b0, $sformatf("px%0d", i));
      check_cnt("px_writes", n_wr - w0, 16);
      check_cnt("px_frame_done", n_fd - f0, 0);
      check_cnt("px_timeout", n_err - e0, 0);
   endtask

   task automatic test_pair();
      int w0;
      w0 = n_wr;
      send_pixel(16'hABCD, 5'd16, 1'b0, "pair_abcd");
      idle(5);
      check_cnt("pair_writes", n_wr - w0, 1);
      total++;
      if ({bus.ram_waddr, bus.ram_wdata} !== {5'd16, 16'hABCD}) begin
         bad++;
         $display("FAIL hold: a=%0d d=%h want a=16 d=abcd",
                  bus.ram_waddr, bus.ram_wdata);
      end
   endtask

   task automatic test_timeout();
      logic wr;
      logic [AW-1:0] a;
      logic [15:0] d;
      logic fd;
      int seen, w0, e0;
      w0 = n_wr; e0 = n_err;
      seen = -1;
      send_byte(8'h12, wr, a, d, fd);
      for (int k = 1; k <= TO + 10; k++) begin
         @(negedge clk);
         if (bus.err_timeout && seen < 0) seen = k;
      end
      check_cnt("timeout_cycle", seen, TO);
      check_cnt("timeout_nowrite", n_wr - w0, 0);
      send_pixel(16'h3456, 5'd17, 1'b0, "after_timeout");
      check_cnt("timeout_pulses", n_err - e0, 1);
   endtask

   task automatic test_timeout_edge();
      logic wr;
      logic [AW-1:0] a;
      logic [15:0] d;
      logic fd;
      int e0;
      e0 = n_err;
      send_byte(8'h77, wr, a, d, fd);
      idle(TO - 1);
      send_byte(8'h88, wr, a, d, fd);
      total++;
      if ({wr, a, d} !== {1'b1, 5'd18, 16'h7788}) begin
         bad++;
         $display("FAIL timeout_edge: wr=%b a=%0d d=%h want wr=1 a=18 d=7788",
                  wr, a, d);
      end
      idle(TO + 5);
      check_cnt("timeout_edge_err", n_err - e0, 0);
   endtask

   task automatic test_back_to_back();
      logic wr;
      logic [AW-1:0] a;
      logic [15:0] d;
      logic fd;
      send_byte(8'h11, wr, a, d, fd);
      send_byte(8'h22, wr, a, d, fd);
      total++;
      if ({wr, a, d} !== {1'b1, 5'd19, 16'h1122}) begin
         bad++;
         $display("FAIL b2b_first: wr=%b a=%0d d=%h want wr=1 a=19 d=1122",
                  wr, a, d);
      end
      send_byte(8'h33, wr, a, d, fd);
      total++;
      if (wr !== 1'b0) begin
         bad++;
         $display("FAIL b2b_gap: wr=%b want 0", wr);
      end
      send_byte(8'h44, wr, a, d, fd);
      total++;
      if ({wr, a, d} !== {1'b1, 5'd20, 16'h3344}) begin
         bad++;
         $display("FAIL b2b_second: wr=%b a=%0d d=%h want wr=1 a=20 d=3344",
                  wr, a, d);
      end
      idle(GAP);
   endtask

   task automatic test_wrap();
      int f0;
      f0 = n_fd;
      send_pixel(16'h0101, 5'd21, 1'b0, "wrap_21");
      send_pixel(16'h0202, 5'd22, 1'b0, "wrap_22");
      send_pixel(16'hFFFF, 5'd23, 1'b1, "wrap_last");
      send_pixel(16'h0001, 5'd0, 1'b0, "wrap_first");
      check_cnt("wrap_frame_done", n_fd - f0, 1);
   endtask

   task automatic test_sync_clr();
      logic wr;
      logic [AW-1:0] a;
      logic [15:0] d;
      logic fd;
      int w0;
      w0 = n_wr;
      send_byte(8'h55, wr, a, d, fd);
      idle(GAP);
      bus.sync_clr = 1'b1;
      send_byte(8'h66, wr, a, d, fd);
      bus.sync_clr = 1'b0;
      total++;
      if (wr !== 1'b0) begin
         bad++;
         $display("FAIL sync_drop: wr=%b want 0", wr);
      end
      idle(GAP);
      check_cnt("sync_nowrite", n_wr - w0, 0);
      send_pixel(16'h0102, 5'd0, 1'b0, "sync_restart");
   endtask

   task automatic test_reset_mid_pair();
      logic wr;
      logic [AW-1:0] a;
      logic [15:0] d;
      logic fd;
      int w0;
      send_byte(8'h99, wr, a, d, fd);
      idle(10);
      rst_n = 1'b0;
      #1;
      check_outs_zero("midpair_reset");
      idle(3);
      rst_n = 1'b1;
      idle(3);
      w0 = n_wr;
      send_pixel(16'h0A0B, 5'd0, 1'b0, "midpair_after");
      check_cnt("midpair_writes", n_wr - w0, 1);
   endtask

   task automatic test_reset_mid_write();
      logic wr;
      logic [AW-1:0] a;
      logic [15:0] d;
      logic fd;
      send_byte(8'h13, wr, a, d, fd);
      send_byte(8'h57, wr, a, d, fd);
      total++;
      if ({wr, a, d} !== {1'b1, 5'd1, 16'h1357}) begin
         bad++;
         $display("FAIL midwrite_pre: wr=%b a=%0d d=%h want wr=1 a=1 d=1357",
                  wr, a, d);
      end
      rst_n = 1'b0;
      #1;
      check_outs_zero("midwrite_reset");
      idle(2);
      rst_n = 1'b1;
      idle(2);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      n_wr  = 0;
      n_fd  = 0;
      n_err = 0;
      test_reset();
      test_pixels();
      test_pair();
      test_timeout();
      test_timeout_edge();
      test_back_to_back();
      test_wrap();
      test_sync_clr();
      test_reset_mid_pair();
      test_reset_mid_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_pixel_packer.md
Name: uart_pixel_packer

Overview:
- Sits between the UART byte receiver and the frame RAM of the UART-to-TFT display path.
- Packs received bytes in pairs, high byte first, into 16-bit RGB565 pixels.
- Generates sequential frame-RAM write addresses and flags frame completion.
- Resynchronises byte pairing after a stalled link, using an inter-byte timeout.

Parameters:
- PIXELS, 130560, pixels per frame (480x272); address wraps after PIXELS-1.
- ADDR_W, 17, RAM address width; must satisfy 2^ADDR_W >= PIXELS.
- TIMEOUT_CYC, 21700, Clk cycles allowed between high and low byte (about 5 byte times at 115200 baud, 50 MHz).

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte; valid only while rx_done=1.
- rx_done  in  1  one-cycle strobe from the UART receiver.
- sync_clr  in  1  synchronous frame restart: address to 0, pairing to high byte.
- ram_wren  out  1  frame RAM write enable, one-cycle pulse.
- ram_waddr  out  ADDR_W  frame RAM write address.
- ram_wdata  out  16  pixel word {high byte, low byte}.
- frame_done  out  1  one-cycle pulse, coincident with the write of address PIXELS-1.
- err_timeout  out  1  one-cycle pulse when a pending high byte is discarded.

Behaviour:
- Reset (async, Reset_n=0): state=WAIT_HI; hi_reg=0; addr=0; timeout counter=0; ram_wren=0; ram_waddr=0; ram_wdata=0; frame_done=0; err_timeout=0.
- States: WAIT_HI, WAIT_LO.
- WAIT_HI, rx_done=1: latch hi_reg<=rx_data, clear timeout counter, go to WAIT_LO. No write.
- WAIT_LO, rx_done=1:
  - Next cycle: ram_wren=1, ram_wdata={hi_reg, rx_data}, ram_waddr=addr.
  - Then addr<=addr+1, or 0 if addr==PIXELS-1. Go to WAIT_HI.
  - Latency: 1 cycle from the low-byte strobe to the write pulse.
- WAIT_LO, no rx_done: counter increments each cycle. When it reaches TIMEOUT_CYC-1:
  - discard hi_reg and go to WAIT_HI;
  - err_timeout=1 on the following cycle;
  - addr unchanged.
- Timeout and rx_done in the same cycle: rx_done wins. The byte is taken as the low byte and no error is raised.
- frame_done: asserted in the same cycle as ram_wren for address PIXELS-1. The next write goes to address 0.
- sync_clr=1: addr<=0, state<=WAIT_HI, counter cleared. It has priority over a coincident rx_done, which is dropped with no write. An already-registered write pulse still completes in that cycle.
- ram_waddr/ram_wdata hold their last values while ram_wren=0.
- Reset mid-pair: the pending high byte is lost and no write is issued.
- Reset mid-write: the registered pulse is forced low immediately.
- Back-to-back rx_done is legal. At 115200 baud strobes are at least 4340 cycles apart, but the block accepts strobes on consecutive cycles with no loss.
- Widths: addr compares against PIXELS-1 at ADDR_W bits. No arithmetic overflow past the wrap.

Decomposition:
- Shared package uart_tft_pkg holds:
  - constants: H_DISP=480, V_DISP=272, FRAME_PIXELS, FB_ADDR_W=17, CLK_HZ=50_000_000, BAUD=115200, BYTE_CYC=4340;
  - state encoding for WAIT_HI/WAIT_LO.
- One sub-module: pixel_addr_gen, the wrap counter with clear and frame_done generation.
- Pairing FSM and timeout stay in the top.

Test Plan:
- Send 16 pixels with values 0x0000..0x000F as byte pairs 00,00 / 00,01 / … / 00,0F via rx_done strobes 4340 cycles apart:
  - 16 ram_wren pulses, each 1 cycle after its low-byte strobe;
  - addr 0..15, data 0x0000..0x000F;
  - no frame_done, no err_timeout.
- Send pair AB,CD:
  - exactly one write, data 0xABCD, at the current address.
- Send high byte 0x12, wait TIMEOUT_CYC+10 cycles, then send bytes 34,56:
  - err_timeout pulses once;
  - write data is 0x3456, not 0x1234;
  - addr not advanced by the dropped byte.
- Preload (PIXELS=8 override) with 7 pixels, then send pixel 0xFFFF:
  - write at addr 7 with frame_done=1 in the same cycle;
  - next pixel 0x0001 writes to addr 0.
- Send high byte 0x55, assert sync_clr together with the next rx_done carrying 0x66:
  - no write;
  - next pair 01,02 writes 0x0102 at addr 0.
- Deassert Reset_n between the two bytes of a pair, release, send 0A,0B:
  - all outputs 0 during reset;
  - single write 0x0A0B at addr 0.
